// File: rtl/cook_timer.sv
// BCD mm:ss countdown timer: captures a keyed duration, counts it down once per
// second while running, and flags completion.
module cook_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] durationIn,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  output logic [15:0] count,
  output logic        running,
  output logic        paused,
  output logic        tick,
  output logic        done,
  output logic        invalid
);

  // state    | meaning
  // S_IDLE   | cleared, waiting for a valid duration
  // S_LOADED | duration captured, waiting for start
  // S_RUN    | counting down one second per TICK_DIV cycles
  // S_PAUSE  | countdown frozen, partial second retained
  // S_DONE   | reached 00:00, done held high
  typedef enum logic [2:0] {S_IDLE, S_LOADED, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             load_ok;

  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
           (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  // One-second borrow chain: S1 -> S10 (base 6) -> M1 -> M10.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign load_ok = bcd_valid(durationIn);

  // div_cnt holds the cycles left in the current second; it is only reloaded on
  // a start from LOADED, so a resume from PAUSE finishes the partial second.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      div_cnt <= '0;
      running <= 1'b0;
      paused  <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      tick    <= 1'b0;
      invalid <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        count   <= '0;
        div_cnt <= '0;
        running <= 1'b0;
        paused  <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            if (div_cnt == '0) begin
              div_cnt <= DIV_LAST;
              tick    <= 1'b1;
              count   <= bcd_dec(count);
            end else begin
              div_cnt <= div_cnt - DIV_W'(1);
            end
            if ((div_cnt == '0) && (count == 16'h0001)) begin
              state   <= S_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (pause) begin
              state   <= S_PAUSE;
              running <= 1'b0;
              paused  <= 1'b1;
            end
          end
          S_PAUSE: begin
            if (!pause && start) begin
              state   <= S_RUN;
              running <= 1'b1;
              paused  <= 1'b0;
            end
          end
          S_LOADED: begin
            if (!pause) begin
              if (start) begin
                if (count != '0) begin
                  state   <= S_RUN;
                  running <= 1'b1;
                  div_cnt <= DIV_LAST;
                end
              end else if (load) begin
                if (load_ok) count   <= durationIn;
                else         invalid <= 1'b1;
              end
            end
          end
          S_IDLE, S_DONE: begin
            if (!pause && !start && load) begin
              if (load_ok) begin
                state <= S_LOADED;
                count <= durationIn;
                done  <= 1'b0;
              end else begin
                invalid <= 1'b1;
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            count   <= '0;
            div_cnt <= '0;
            running <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
